// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU.
//   alu_op_t    : 4-bit opcode encoding seen on alu_op_i
//   alu_state_t : control FSM states
//   is_long_op  : opcodes that iterate over WIDTH cycles (ignores the B==0 shortcut)
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_MUL    = 4'h2,
    OP_DIV    = 4'h3,
    OP_AND    = 4'h4,
    OP_OR     = 4'h5,
    OP_XOR    = 4'h6,
    OP_NOT    = 4'h7,
    OP_LEZ    = 4'h8,
    OP_LTZ    = 4'h9,
    OP_GTZ    = 4'hA,
    OP_EQT    = 4'hB,
    OP_NET    = 4'hC,
    OP_REM    = 4'hD,
    OP_PASS_E = 4'hE,
    OP_PASS_F = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  function automatic logic is_long_op(alu_op_t op, logic fast_mul);
    return ((op == OP_MUL) && !fast_mul) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute stage and the multicycle ALU.
//   request : valid_i, ready_o, data1_i, data2_i, alu_op_i
//   response: valid_o, ready_i, result_o, zero_o, div_zero_o
// slave  = ALU side, master = pipeline side.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [3:0]       alu_op_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             div_zero_o;

  modport slave (
    input  valid_i, data1_i, data2_i, alu_op_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, div_zero_o
  );

  modport master (
    output valid_i, data1_i, data2_i, alu_op_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, div_zero_o
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   start     : load dividend/divisor and begin (divisor must be nonzero)
//   busy      : iteration in progress
//   done      : high during the last iteration cycle
//   quotient  : value after the current step (final when done=1)
//   remainder : value after the current step (final when done=1)
// The outputs show the post-step value combinationally so the caller can
// register the final result on the same edge as the last step.
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;

  // Partial remainder needs one extra bit: rem < divisor, so 2*rem+1 can
  // exceed WIDTH bits before the trial subtraction.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CNT_LAST);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

endmodule

// File: rtl/alu_multicycle.sv
// Registered multicycle ALU for the execute stage.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   alu          : request/response handshake bundle (slave side)
// Single-cycle ops (and MUL when FAST_MUL=1) finish one cycle after accept.
// MUL (shift-add) and DIV/REM (restoring) take WIDTH+1 cycles; DIV/REM by
// zero finish in one cycle with div_zero_o set.
//
// state | meaning
// IDLE  | no result pending, ready for a request
// MUL   | shift-add multiply iterating
// DIV   | divider iterating for DIV or REM
// DONE  | result on outputs, held until the consumer takes it
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic clk_i,
  input logic rst_i,
  alu_multicycle_if.slave alu
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_d, op_in;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic             ready, accept, div_op;
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  function automatic logic [WIDTH-1:0] single_op(alu_op_t op, logic [WIDTH-1:0] a,
                                                 logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_LEZ:  r = {{(WIDTH-1){1'b0}}, a[WIDTH-1] | (a == '0)};
      OP_LTZ:  r = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
      OP_GTZ:  r = {{(WIDTH-1){1'b0}}, ~a[WIDTH-1] & (a != '0)};
      OP_EQT:  r = {{(WIDTH-1){1'b0}}, a == b};
      OP_NET:  r = {{(WIDTH-1){1'b0}}, a != b};
      default: r = a;
    endcase
    return r;
  endfunction

  assign op_in    = alu_op_t'(alu.alu_op_i);
  assign div_op   = (op_in == OP_DIV) || (op_in == OP_REM);
  assign ready    = (state_q == IDLE) || ((state_q == DONE) && alu.ready_i);
  assign accept   = alu.valid_i && ready;
  assign acc_step = acc_q + (mp_q[0] ? mc_q : '0);

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (div_start),
    .dividend  (alu.data1_i),
    .divisor   (alu.data2_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dz_d      = dz_q;
    div_start = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          op_d  = op_in;
          dz_d  = 1'b0;
          cnt_d = '0;
          if (div_op && (alu.data2_i == '0)) begin
            dz_d     = 1'b1;
            result_d = (op_in == OP_DIV) ? '1 : alu.data1_i;
            state_d  = DONE;
          end else if (is_long_op(op_in, FAST_MUL)) begin
            if (op_in == OP_MUL) begin
              acc_d   = '0;
              mc_d    = alu.data1_i;
              mp_d    = alu.data2_i;
              state_d = MUL;
            end else begin
              div_start = 1'b1;
              state_d   = DIV;
            end
          end else begin
            result_d = single_op(op_in, alu.data1_i, alu.data2_i);
            state_d  = DONE;
          end
        end else if ((state_q == DONE) && alu.ready_i) begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = acc_step;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step;
          state_d  = DONE;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (div_busy && div_done) begin
          result_d = (op_q == OP_DIV) ? div_quo : div_rem;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      mc_q     <= '0;
      mp_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
    end
  end

  assign alu.ready_o    = ready;
  assign alu.valid_o    = (state_q == DONE);
  assign alu.result_o   = result_q;
  assign alu.zero_o     = zero_q;
  assign alu.div_zero_o = dz_q;

endmodule
